// File: rtl/riscv_pkg.sv
// Shared core types and constants.
// Used by the ID/EX, EX/MEM, MEM/WB, forwarding and writeback blocks.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/wb_regfile_bank.sv
// Integer register storage: one write port, two async read ports.
// x0 is never stored and always reads zero.
module regfile_bank #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREGS  = riscv_pkg::NREGS,
  parameter int ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]   rdata1,
  output logic [XLEN-1:0]   rdata2
);
  import riscv_pkg::*;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != X0) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == X0) ? '0 : regs_q[raddr1];
    rdata2 = (raddr2 == X0) ? '0 : regs_q[raddr2];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result mux, register file, commit counter.
// Define REGFILE_BYPASS_EN for write-first same-cycle reads.
module wb_regfile #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREGS  = riscv_pkg::NREGS,
  parameter int ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_to_reg,
  input  logic              reg_write_en,
  input  logic [XLEN-1:0]   data,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]   read_data1,
  output logic [XLEN-1:0]   read_data2,
  output logic [XLEN-1:0]   wb_data,
  output logic [63:0]       wb_write_count
);
  import riscv_pkg::*;

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);

  logic            commit;
  logic [XLEN-1:0] bank_rd1;
  logic [XLEN-1:0] bank_rd2;
  logic [63:0]     cnt_q;
  logic [63:0]     cnt_d;

  always_comb begin
    wb_data = mem_to_reg ? data : alu_out;
    commit  = reg_write_en && (rd != X0);
  end

  regfile_bank #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .we     (reg_write_en),
    .waddr  (rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (bank_rd1),
    .rdata2 (bank_rd2)
  );

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    read_data1 = (commit && rs1 == rd) ? wb_data : bank_rd1;
    read_data2 = (commit && rs2 == rd) ? wb_data : bank_rd2;
  end
`else
  // Read-first: the hazard unit covers the WB-to-ID overlap.
  always_comb begin
    read_data1 = bank_rd1;
    read_data2 = bank_rd2;
  end
`endif

  always_comb begin
    cnt_d = commit ? cnt_q + 64'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wb_write_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against an array-based model.
// Honours REGFILE_BYPASS_EN to select the expected read behaviour.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        mem_to_reg;
  logic        reg_write_en;
  logic [63:0] data;
  logic [63:0] alu_out;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic [63:0] wb_data;
  logic [63:0] wb_write_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_regs [32];
  logic [63:0] m_cnt;

  wb_regfile dut (
    .clk            (clk),
    .reset          (reset),
    .mem_to_reg     (mem_to_reg),
    .reg_write_en   (reg_write_en),
    .data           (data),
    .alu_out        (alu_out),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .read_data1     (read_data1),
    .read_data2     (read_data2),
    .wb_data        (wb_data),
    .wb_write_count (wb_write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] m_wb();
    return mem_to_reg ? data : alu_out;
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (reg_write_en && rd != 5'd0 && a == rd) return m_wb();
`endif
    return m_regs[a];
  endfunction

  // Advance one clock and apply the architectural effect to the model.
  task automatic tick();
    logic [63:0] v;
    v = m_wb();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_cnt = 64'd0;
    end else if (reg_write_en && rd != 5'd0) begin
      m_regs[rd] = v;
      m_cnt = m_cnt + 64'd1;
    end
    #1;
  endtask

  task automatic drive(input logic mtr, input logic we,
                       input logic [63:0] d, input logic [63:0] a,
                       input logic [4:0] w, input logic [4:0] r1,
                       input logic [4:0] r2);
    mem_to_reg   = mtr;
    reg_write_en = we;
    data         = d;
    alu_out      = a;
    rd           = w;
    rs1          = r1;
    rs2          = r2;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b1, 64'h0, 64'hAA, 5'd5, 5'd5, 5'd0);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd5, 5'd17);
    checks++;
    if (read_data1 !== 64'd0) begin
      errors++;
      $display("FAIL reset_rd1: got %h want 0", read_data1);
    end
    checks++;
    if (read_data2 !== 64'd0) begin
      errors++;
      $display("FAIL reset_rd2: got %h want 0", read_data2);
    end
    checks++;
    if (wb_write_count !== 64'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", wb_write_count);
    end
  endtask

  task automatic test_alu_wb();
    drive(1'b0, 1'b1, 64'hFFFF, 64'h1234, 5'd3, 5'd0, 5'd0);
    checks++;
    if (wb_data !== 64'h1234) begin
      errors++;
      $display("FAIL alu_wbdata: got %h want 1234", wb_data);
    end
    tick();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd3, 5'd0);
    checks++;
    if (read_data1 !== 64'h1234) begin
      errors++;
      $display("FAIL alu_rd1: got %h want 1234", read_data1);
    end
    checks++;
    if (wb_write_count !== 64'd1) begin
      errors++;
      $display("FAIL alu_cnt: got %0d want 1", wb_write_count);
    end
  endtask

  task automatic test_load_wb();
    drive(1'b1, 1'b1, 64'hDEADBEEF_00000001, 64'h77, 5'd7, 5'd0, 5'd0);
    checks++;
    if (wb_data !== 64'hDEADBEEF_00000001) begin
      errors++;
      $display("FAIL load_wbdata: got %h want deadbeef00000001", wb_data);
    end
    tick();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd7);
    checks++;
    if (read_data2 !== 64'hDEADBEEF_00000001) begin
      errors++;
      $display("FAIL load_rd2: got %h want deadbeef00000001", read_data2);
    end
  endtask

  task automatic test_x0();
    logic [63:0] c0;
    c0 = m_cnt;
    drive(1'b0, 1'b1, 64'h0, 64'h55, 5'd0, 5'd0, 5'd0);
    checks++;
    if (read_data1 !== 64'd0) begin
      errors++;
      $display("FAIL x0_pre: got %h want 0", read_data1);
    end
    tick();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (read_data1 !== 64'd0) begin
      errors++;
      $display("FAIL x0_rd1: got %h want 0", read_data1);
    end
    checks++;
    if (wb_write_count !== c0) begin
      errors++;
      $display("FAIL x0_cnt: got %0d want %0d", wb_write_count, c0);
    end
  endtask

  task automatic test_same_cycle();
    logic [63:0] want;
    drive(1'b0, 1'b1, 64'h0, 64'h10, 5'd4, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 64'h0, 64'h20, 5'd4, 5'd4, 5'd4);
`ifdef REGFILE_BYPASS_EN
    want = 64'h20;
`else
    want = 64'h10;
`endif
    checks++;
    if (read_data1 !== want) begin
      errors++;
      $display("FAIL same_pre_rd1: got %h want %h", read_data1, want);
    end
    checks++;
    if (read_data2 !== want) begin
      errors++;
      $display("FAIL same_pre_rd2: got %h want %h", read_data2, want);
    end
    tick();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd4, 5'd0);
    checks++;
    if (read_data1 !== 64'h20) begin
      errors++;
      $display("FAIL same_post_rd1: got %h want 20", read_data1);
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    drive(1'b0, 1'b1, 64'h0, 64'h99, 5'd9, 5'd9, 5'd4);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd9, 5'd4);
    checks++;
    if (read_data1 !== 64'd0 || read_data2 !== 64'd0) begin
      errors++;
      $display("FAIL rstpri_regs: got %h %h want 0 0",
               read_data1, read_data2);
    end
    checks++;
    if (wb_write_count !== 64'd0) begin
      errors++;
      $display("FAIL rstpri_cnt: got %0d want 0", wb_write_count);
    end
    drive(1'b0, 1'b1, 64'h0, 64'h99, 5'd9, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd9, 5'd0);
    checks++;
    if (read_data1 !== 64'h99 || wb_write_count !== 64'd1) begin
      errors++;
      $display("FAIL rstpri_first: got %h cnt %0d want 99 cnt 1",
               read_data1, wb_write_count);
    end
  endtask

  task automatic test_random();
    logic [4:0]  w;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [63:0] e1;
    logic [63:0] e2;
    for (int n = 0; n < 400; n++) begin
      w  = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            {$urandom, $urandom}, {$urandom, $urandom}, w, r1, r2);
      e1 = m_read(r1);
      e2 = m_read(r2);
      checks++;
      if (wb_data !== m_wb()) begin
        errors++;
        $display("FAIL rnd_wb[%0d]: got %h want %h", n, wb_data, m_wb());
      end
      checks++;
      if (read_data1 !== e1) begin
        errors++;
        $display("FAIL rnd_rd1[%0d] rs1=%0d: got %h want %h",
                 n, r1, read_data1, e1);
      end
      checks++;
      if (read_data2 !== e2) begin
        errors++;
        $display("FAIL rnd_rd2[%0d] rs2=%0d: got %h want %h",
                 n, r2, read_data2, e2);
      end
      tick();
      checks++;
      if (wb_write_count !== m_cnt) begin
        errors++;
        $display("FAIL rnd_cnt[%0d]: got %0d want %0d",
                 n, wb_write_count, m_cnt);
      end
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'(i), 5'(31 - i));
      checks++;
      if (read_data1 !== m_read(5'(i)) ||
          read_data2 !== m_read(5'(31 - i))) begin
        errors++;
        $display("FAIL sweep[%0d]: got %h %h want %h %h", i,
                 read_data1, read_data2,
                 m_read(5'(i)), m_read(5'(31 - i)));
      end
    end
  endtask

  task automatic test_counter_wrap();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0);
    force dut.cnt_q = '1;
    #1;
    release dut.cnt_q;
    m_cnt = '1;
    drive(1'b0, 1'b1, 64'h0, 64'h3C, 5'd12, 5'd12, 5'd0);
    tick();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd12, 5'd0);
    checks++;
    if (wb_write_count !== 64'd0 || m_cnt !== 64'd0) begin
      errors++;
      $display("FAIL wrap_cnt: got %0d want 0", wb_write_count);
    end
    checks++;
    if (read_data1 !== 64'h3C) begin
      errors++;
      $display("FAIL wrap_rd1: got %h want 3c", read_data1);
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_cnt = 64'd0;
    drive(1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    test_reset();
    test_alu_wb();
    test_load_wb();
    test_x0();
    test_same_cycle();
    test_reset_priority();
    test_random();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
